// File: rtl/hps_word_buffer.sv
// -----------------------------------------------------------------------------
// hps_word_buffer
//   Buffers completed 32-bit image words from the bit-queuing stage in a small
//   FIFO and hands them to the HPS over a toggle handshake (present, wait for
//   ack toggle, pop). Counts words per image frame.
//
// Parameters
//   DEPTH        FIFO entries (power of 2, >= 2)
//   FRAME_WORDS  words per image frame
//
// Ports
//   iCLK        clock, rising edge
//   iRST        asynchronous active-low reset
//   iData       word from bit-queuing stage
//   iWR         one-cycle write strobe
//   iClear      synchronous flush of FIFO, frame counter and sticky flags
//   iHPS_ACK    HPS ack level, toggles once per consumed word (async)
//   oHPS_DATA   word presented to the HPS
//   oHPS_VALID  oHPS_DATA stable and unread
//   oCount      FIFO occupancy 0..DEPTH
//   oFull       oCount == DEPTH
//   oOverflow   sticky: a write was dropped
//   oAckErr     sticky: ack toggle seen while no word was presented
//   oFrameDone  one-cycle pulse after the pop of a frame's last word
//   oChecksum   (HPS_WORD_CHECKSUM_EN only) running XOR of the current frame
//
// Optional feature macro: HPS_WORD_CHECKSUM_EN
// -----------------------------------------------------------------------------
module hps_word_buffer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned FRAME_WORDS = 25
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic [31:0]              iData,
    input  logic                     iWR,
    input  logic                     iClear,
    input  logic                     iHPS_ACK,
    output logic [31:0]              oHPS_DATA,
    output logic                     oHPS_VALID,
    output logic [$clog2(DEPTH):0]   oCount,
    output logic                     oFull,
    output logic                     oOverflow,
    output logic                     oAckErr,
`ifdef HPS_WORD_CHECKSUM_EN
    output logic                     oFrameDone,
    output logic [31:0]              oChecksum
`else
    output logic                     oFrameDone
`endif
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = AW + 1;
    localparam int unsigned FW_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PRESENT,
        ST_GAP
    } state_e;

    // Storage and state
    logic [31:0]     mem [DEPTH];
    state_e          state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_q, full_d;
    logic            ovf_q, ovf_d;
    logic            ackerr_q, ackerr_d;
    logic            fdone_q, fdone_d;
    logic [FW_W-1:0] fcnt_q, fcnt_d;
    logic [31:0]     data_q, data_d;
    logic            valid_q, valid_d;
`ifdef HPS_WORD_CHECKSUM_EN
    logic [31:0]     chk_q, chk_d;
`endif

    // Ack synchroniser: two flops for metastability, third for edge detect
    logic ack_s1_q, ack_s2_q, ack_s3_q;
    logic ack_evt;
    logic pop;
    logic push;
    logic frame_last;

    assign ack_evt    = ack_s2_q ^ ack_s3_q;
    assign pop        = (state_q == ST_PRESENT) && ack_evt && !iClear;
    // A full FIFO still accepts a write when a slot frees on the same edge
    assign push       = iWR && !iClear && (!full_q || pop);
    assign frame_last = (fcnt_q == FW_W'(FRAME_WORDS - 1));

    // Synchroniser flops are deliberately untouched by iClear
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
            ack_s3_q <= 1'b0;
        end else begin
            ack_s1_q <= iHPS_ACK;
            ack_s2_q <= ack_s1_q;
            ack_s3_q <= ack_s2_q;
        end
    end

    // Word storage; contents are don't-care until written
    always_ff @(posedge iCLK) begin
        if (push) begin
            mem[wptr_q] <= iData;
        end
    end

    // Next-state: read FSM, pointers, occupancy, flags, frame counter
    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        ackerr_d = ackerr_q;
        fdone_d  = 1'b0;
        fcnt_d   = fcnt_q;
        data_d   = data_q;
        valid_d  = valid_q;
`ifdef HPS_WORD_CHECKSUM_EN
        chk_d    = chk_q;
`endif

        if (iClear) begin
            state_d  = ST_IDLE;
            wptr_d   = '0;
            rptr_d   = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            ackerr_d = 1'b0;
            fcnt_d   = '0;
            valid_d  = 1'b0;
`ifdef HPS_WORD_CHECKSUM_EN
            chk_d    = '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (count_q != '0) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    data_d  = mem[rptr_q];
                    valid_d = 1'b1;
                    state_d = ST_PRESENT;
                end
                ST_PRESENT: begin
                    if (ack_evt) begin
                        valid_d = 1'b0;
                        state_d = ST_GAP;
                    end
                end
                ST_GAP: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (ack_evt && (state_q != ST_PRESENT)) begin
                ackerr_d = 1'b1;
            end
            if (iWR && !push) begin
                ovf_d = 1'b1;
            end
            if (push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d  = rptr_q + AW'(1);
                fdone_d = frame_last;
                fcnt_d  = frame_last ? '0 : fcnt_q + FW_W'(1);
`ifdef HPS_WORD_CHECKSUM_EN
                // First pop of a frame restarts the XOR
                chk_d   = (fcnt_q == '0) ? data_q : (chk_q ^ data_q);
`endif
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        full_d = (count_d == CW'(DEPTH));
    end

    // State register
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q  <= ST_IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ackerr_q <= 1'b0;
            fdone_q  <= 1'b0;
            fcnt_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
`ifdef HPS_WORD_CHECKSUM_EN
            chk_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
            ackerr_q <= ackerr_d;
            fdone_q  <= fdone_d;
            fcnt_q   <= fcnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
`ifdef HPS_WORD_CHECKSUM_EN
            chk_q    <= chk_d;
`endif
        end
    end

    assign oHPS_DATA  = data_q;
    assign oHPS_VALID = valid_q;
    assign oCount     = count_q;
    assign oFull      = full_q;
    assign oOverflow  = ovf_q;
    assign oAckErr    = ackerr_q;
    assign oFrameDone = fdone_q;
`ifdef HPS_WORD_CHECKSUM_EN
    assign oChecksum  = chk_q;
`endif

endmodule

// File: tb/tb_hps_word_buffer.sv
// -----------------------------------------------------------------------------
// tb_hps_word_buffer
//   Self-checking bench for hps_word_buffer. A queue-based model tracks the
//   buffered words, sticky overflow, position within the frame and the
//   frame XOR; the HPS side is emulated by toggling the ack level.
// -----------------------------------------------------------------------------
module tb_hps_word_buffer;

    localparam int DEPTH = 16;
    localparam int FW    = 25;

    logic        iCLK;
    logic        iRST;
    logic [31:0] iData;
    logic        iWR;
    logic        iClear;
    logic        iHPS_ACK;
    logic [31:0] oHPS_DATA;
    logic        oHPS_VALID;
    logic [4:0]  oCount;
    logic        oFull;
    logic        oOverflow;
    logic        oAckErr;
    logic        oFrameDone;
`ifdef HPS_WORD_CHECKSUM_EN
    logic [31:0] oChecksum;
`endif

    hps_word_buffer #(
        .DEPTH       (DEPTH),
        .FRAME_WORDS (FW)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iData      (iData),
        .iWR        (iWR),
        .iClear     (iClear),
        .iHPS_ACK   (iHPS_ACK),
        .oHPS_DATA  (oHPS_DATA),
        .oHPS_VALID (oHPS_VALID),
        .oCount     (oCount),
        .oFull      (oFull),
        .oOverflow  (oOverflow),
        .oAckErr    (oAckErr),
`ifdef HPS_WORD_CHECKSUM_EN
        .oFrameDone (oFrameDone),
        .oChecksum  (oChecksum)
`else
        .oFrameDone (oFrameDone)
`endif
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int          n_vec;
    int          n_err;
    logic [31:0] model_q[$];
    bit          ovf_m;
    int          frame_pos;
    logic [31:0] xor_m;
    int          fd_total;

    // Single comparison point for the whole bench
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        ovf_m     = 1'b0;
        frame_pos = 0;
        xor_m     = '0;
    endtask

    // Remove the head word, advance frame position and frame XOR
    task automatic model_pop(output logic [31:0] w, output bit last);
        w = model_q.pop_front();
        if (frame_pos == 0) xor_m = w;
        else                xor_m = xor_m ^ w;
        frame_pos++;
        last = (frame_pos == FW);
        if (last) frame_pos = 0;
    endtask

    task automatic push_word(input logic [31:0] d);
        @(negedge iCLK);
        iWR   = 1'b1;
        iData = d;
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else                        ovf_m = 1'b1;
        @(negedge iCLK);
        iWR = 1'b0;
        chk("push_count", 32'(oCount), 32'(model_q.size()));
        chk("push_full", 32'(oFull), 32'(model_q.size() == DEPTH));
        chk("push_ovf", 32'(oOverflow), 32'(ovf_m));
    endtask

    task automatic wait_valid(output bit ok);
        int t;
        t = 0;
        while (!oHPS_VALID && t < 12) begin
            @(negedge iCLK);
            t++;
        end
        ok = oHPS_VALID;
        if (!ok) chk("valid_timeout", 32'(oHPS_VALID), 32'd1);
    endtask

    // HPS consumes one word: check it, toggle ack, watch for the pop
    task automatic pop_one();
        bit          ok;
        bit          fd;
        bit          last;
        int          t;
        logic [31:0] w;
        wait_valid(ok);
        if (!ok) return;
        chk("pop_data", oHPS_DATA, model_q[0]);
        model_pop(w, last);
        iHPS_ACK = ~iHPS_ACK;
        fd = 1'b0;
        t  = 0;
        do begin
            @(negedge iCLK);
            t++;
            if (oFrameDone) fd = 1'b1;
        end while (oHPS_VALID && t < 8);
        chk("pop_valid_drop", 32'(oHPS_VALID), 32'd0);
        chk("pop_held_data", oHPS_DATA, w);
        chk("pop_frame_done", 32'(fd), 32'(last));
        chk("pop_count", 32'(oCount), 32'(model_q.size()));
`ifdef HPS_WORD_CHECKSUM_EN
        chk("pop_checksum", oChecksum, xor_m);
`endif
        if (fd) fd_total++;
        @(negedge iCLK);
        chk("frame_done_one_cycle", 32'(oFrameDone), 32'd0);
    endtask

    task automatic do_clear();
        @(negedge iCLK);
        iClear = 1'b1;
        @(negedge iCLK);
        iClear = 1'b0;
        model_reset();
        chk("clr_count", 32'(oCount), 32'd0);
        chk("clr_valid", 32'(oHPS_VALID), 32'd0);
        chk("clr_ovf", 32'(oOverflow), 32'd0);
        chk("clr_ackerr", 32'(oAckErr), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(oHPS_VALID), 32'd0);
        chk({tag, "_data"}, oHPS_DATA, 32'd0);
        chk({tag, "_count"}, 32'(oCount), 32'd0);
        chk({tag, "_full"}, 32'(oFull), 32'd0);
        chk({tag, "_ovf"}, 32'(oOverflow), 32'd0);
        chk({tag, "_ackerr"}, 32'(oAckErr), 32'd0);
        chk({tag, "_fdone"}, 32'(oFrameDone), 32'd0);
    endtask

    initial begin
        bit          ok;
        bit          last;
        logic [31:0] w;
        logic [31:0] nw;
        int          pops_done;
        int          nb;
        int          np;

        n_vec    = 0;
        n_err    = 0;
        fd_total = 0;
        iRST     = 1'b1;
        iData    = '0;
        iWR      = 1'b0;
        iClear   = 1'b0;
        iHPS_ACK = 1'b0;
        model_reset();

        // Reset
        #2 iRST = 1'b0;
        repeat (3) @(negedge iCLK);
        check_all_zero("reset");
        iRST = 1'b1;
        repeat (2) @(negedge iCLK);

        // Single word and its two-edge latency
        iWR   = 1'b1;
        iData = 32'hDEADBEEF;
        model_q.push_back(32'hDEADBEEF);
        @(negedge iCLK);
        iWR = 1'b0;
        chk("single_valid_n", 32'(oHPS_VALID), 32'd0);
        chk("single_count", 32'(oCount), 32'd1);
        @(negedge iCLK);
        chk("single_valid_n1", 32'(oHPS_VALID), 32'd0);
        @(negedge iCLK);
        chk("single_valid_n2", 32'(oHPS_VALID), 32'd1);
        chk("single_data", oHPS_DATA, 32'hDEADBEEF);
        pop_one();

        // Fill, overflow, in-order drain
        for (int i = 0; i < DEPTH; i++) push_word($urandom());
        push_word($urandom());
        chk("fill_ovf", 32'(oOverflow), 32'd1);
        chk("fill_ackerr", 32'(oAckErr), 32'd0);
        for (int i = 0; i < DEPTH; i++) pop_one();
        do_clear();

        // Full FIFO with a write coinciding with the pop edge
        for (int i = 0; i < DEPTH; i++) push_word($urandom());
        wait_valid(ok);
        if (ok) begin
            chk("simul_head", oHPS_DATA, model_q[0]);
            nw = $urandom();
            iHPS_ACK = ~iHPS_ACK;
            // Two synchroniser edges then the pop edge
            @(posedge iCLK);
            @(posedge iCLK);
            @(negedge iCLK);
            iWR   = 1'b1;
            iData = nw;
            @(negedge iCLK);
            iWR = 1'b0;
            model_pop(w, last);
            model_q.push_back(nw);
            chk("simul_count", 32'(oCount), 32'd16);
            chk("simul_full", 32'(oFull), 32'd1);
            chk("simul_ovf", 32'(oOverflow), 32'd0);
            chk("simul_valid", 32'(oHPS_VALID), 32'd0);
            chk("simul_held", oHPS_DATA, w);
        end
        for (int i = 0; i < DEPTH; i++) pop_one();

        // Clear with words buffered and presented
        for (int i = 0; i < 3; i++) push_word($urandom());
        wait_valid(ok);
        do_clear();
        repeat (4) @(negedge iCLK);
        chk("clr_stays_empty", 32'(oHPS_VALID), 32'd0);

        // Two random frames with random bursts, gaps and possible overflow
        pops_done = 0;
        fd_total  = 0;
        while (pops_done < 2 * FW) begin
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) push_word($urandom());
            repeat ($urandom_range(0, 3)) @(negedge iCLK);
            np = $urandom_range(1, model_q.size());
            if (np > 2 * FW - pops_done) np = 2 * FW - pops_done;
            for (int i = 0; i < np; i++) begin
                pop_one();
                pops_done++;
            end
        end
        chk("frame_pulses", 32'(fd_total), 32'd2);
        do_clear();

        // Spurious ack on an empty FIFO
        iHPS_ACK = ~iHPS_ACK;
        repeat (5) @(negedge iCLK);
        chk("spur_ackerr", 32'(oAckErr), 32'd1);
        chk("spur_count", 32'(oCount), 32'd0);
        chk("spur_valid", 32'(oHPS_VALID), 32'd0);
        do_clear();

        // Asynchronous reset mid-operation
        iHPS_ACK = ~iHPS_ACK;
        repeat (5) @(negedge iCLK);
        for (int i = 0; i < 5; i++) push_word($urandom());
        wait_valid(ok);
        chk("pre_rst_ackerr", 32'(oAckErr), 32'd1);
        #2 iRST = 1'b0;
        iHPS_ACK = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge iCLK);
        iRST = 1'b1;
        model_reset();
        repeat (6) @(negedge iCLK);
        chk("post_rst_count", 32'(oCount), 32'd0);
        chk("post_rst_valid", 32'(oHPS_VALID), 32'd0);
        chk("post_rst_ackerr", 32'(oAckErr), 32'd0);
        push_word(32'h0BADF00D);
        pop_one();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
